// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
// Module      : morse_pkg
// Description : Shared morse definitions for the player blocks: 2-bit symbol
//               codes, entry state encoding and key-press timing.
// Revision    : 1.0 - initial release
// ============================================================================
package morse_pkg;

  // Symbol codes, 2 bits per symbol
  localparam logic [1:0] SYM_EMPTY = 2'b00;
  localparam logic [1:0] SYM_DOT   = 2'b01;
  localparam logic [1:0] SYM_LINE  = 2'b11;

  // A key press held for at least this many clock cycles decodes as a line;
  // anything shorter is a dot.
  localparam int LINE_CYCLES = 3;

  // Player entry state machine
  typedef enum logic [0:0] {
    ST_ENTRY  = 1'b0,
    ST_LOCKED = 1'b1
  } entry_state_e;

endpackage : morse_pkg
`default_nettype wire

// File: rtl/morse_decoder.sv
`default_nettype none
// ============================================================================
// Module      : morse_decoder
// Description : Times each key press and emits a one-cycle ld_dot or ld_line
//               strobe in the cycle after the key is released.
// Revision    : 1.0 - initial release
// ============================================================================
module morse_decoder
  import morse_pkg::*;
(
  input  logic clock,
  input  logic resetn,
  input  logic user_input,
  output logic ld_dot,
  output logic ld_line
);

  localparam int LW = $clog2(LINE_CYCLES + 1);
  localparam logic [LW-1:0] LEN_LINE = LW'(LINE_CYCLES);

  logic          key_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] len_d;
  logic          release_w;
  logic          dot_q;
  logic          line_q;

  assign release_w = key_q & ~user_input;

  // Press length saturates once a line is certain, keeping the counter narrow
  always_comb begin
    len_d = '0;
    if (user_input) begin
      len_d = (len_q == LEN_LINE) ? len_q : len_q + LW'(1);
    end
  end

  // Key level history, press length and registered classification strobes
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      key_q  <= 1'b0;
      len_q  <= '0;
      dot_q  <= 1'b0;
      line_q <= 1'b0;
    end else begin
      key_q  <= user_input;
      len_q  <= len_d;
      dot_q  <= release_w & (len_q <  LEN_LINE);
      line_q <= release_w & (len_q >= LEN_LINE);
    end
  end

  assign ld_dot  = dot_q;
  assign ld_line = line_q;

endmodule : morse_decoder
`default_nettype wire

// File: rtl/player_entry.sv
`default_nettype none
// ============================================================================
// Module      : player_entry
// Description : Collects decoded morse symbols into characters and commits
//               them into a packed slot array; locks after a done press.
// Revision    : 1.0 - initial release
// ============================================================================
module player_entry
  import morse_pkg::*;
#(
  parameter int SYMBOLS = 5,
  parameter int CHARS   = 4
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         user_input,
  input  logic                         next_input,
  input  logic                         done_input,
  output logic [2*SYMBOLS*CHARS-1:0]   q,
  output logic [2*SYMBOLS-1:0]         cur,
  output logic [$clog2(SYMBOLS+1)-1:0] sym_count,
  output logic [$clog2(CHARS+1)-1:0]   char_count,
  output logic                         locked,
  output logic                         err
);

  localparam int CW  = 2 * SYMBOLS;
  localparam int SCW = $clog2(SYMBOLS + 1);
  localparam int CCW = $clog2(CHARS + 1);
  localparam logic [SCW-1:0] SYM_FULL  = SCW'(SYMBOLS);
  localparam logic [CCW-1:0] CHAR_FULL = CCW'(CHARS);

  entry_state_e         state_q, state_d;
  logic [CW*CHARS-1:0]  q_q, q_d;
  logic [CW-1:0]        cur_q, cur_d, cur_a;
  logic [SCW-1:0]       sym_q, sym_d, sym_a;
  logic [CCW-1:0]       char_q, char_d;
  logic                 err_q, err_d;
  logic                 next_q, done_q;
  logic                 arm_q;

  logic                 ld_dot, ld_line;
  logic                 sym_valid_w;
  logic [1:0]           code_w;
  logic                 next_edge_w, done_edge_w;

  morse_decoder u_decoder (
    .clock      (clock),
    .resetn     (resetn),
    .user_input (user_input),
    .ld_dot     (ld_dot),
    .ld_line    (ld_line)
  );

  // Line wins when both strobes fire together
  assign sym_valid_w = ld_dot | ld_line;
  assign code_w      = ld_line ? SYM_LINE : SYM_DOT;

  // arm_q masks the first cycle after reset so a button held through reset
  // is absorbed into the edge register instead of acting as a press
  assign next_edge_w = arm_q & next_input & ~next_q;
  assign done_edge_w = arm_q & done_input & ~done_q;

  // Next-state: append any symbol first, then commit on next/done edge
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cur_d   = cur_q;
    sym_d   = sym_q;
    char_d  = char_q;
    err_d   = err_q;
    cur_a   = cur_q;
    sym_a   = sym_q;

    if (state_q == ST_ENTRY) begin
      if (sym_valid_w) begin
        if (sym_q == SYM_FULL) begin
          err_d = 1'b1;
        end else begin
          cur_a = {cur_q[CW-3:0], code_w};
          sym_a = sym_q + SCW'(1);
        end
      end

      cur_d = cur_a;
      sym_d = sym_a;

      // A simultaneous next and done still commit exactly once
      if ((next_edge_w || done_edge_w) && (sym_a != '0)) begin
        if (char_q != CHAR_FULL) begin
          for (int i = 0; i < CHARS; i++) begin
            if (char_q == CCW'(i)) begin
              q_d[i*CW +: CW] = cur_a;
            end
          end
          char_d = char_q + CCW'(1);
        end else begin
          err_d = 1'b1;
        end
        cur_d = '0;
        sym_d = '0;
      end

      if (done_edge_w) begin
        state_d = ST_LOCKED;
      end
    end
  end

  // State and storage registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_ENTRY;
      q_q     <= '0;
      cur_q   <= '0;
      sym_q   <= '0;
      char_q  <= '0;
      err_q   <= 1'b0;
      next_q  <= 1'b0;
      done_q  <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cur_q   <= cur_d;
      sym_q   <= sym_d;
      char_q  <= char_d;
      err_q   <= err_d;
      next_q  <= next_input;
      done_q  <= done_input;
      arm_q   <= 1'b1;
    end
  end

  assign q          = q_q;
  assign cur        = cur_q;
  assign sym_count  = sym_q;
  assign char_count = char_q;
  assign err        = err_q;
  assign locked     = (state_q == ST_LOCKED);

endmodule : player_entry
`default_nettype wire

// File: tb/tb_player_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_player_entry
// Description : Directed self-checking bench for player_entry with an
//               expected-value queue popped at each observation point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_player_entry;

  localparam int SYMBOLS = 5;
  localparam int CHARS   = 4;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        user_input = 1'b0;
  logic        next_input = 1'b0;
  logic        done_input = 1'b0;
  logic [39:0] q;
  logic [9:0]  cur;
  logic [2:0]  sym_count;
  logic [2:0]  char_count;
  logic        locked;
  logic        err;

  int checks   = 0;
  int failures = 0;

  string       tag_q[$];
  logic [63:0] val_q[$];

  player_entry #(.SYMBOLS(SYMBOLS), .CHARS(CHARS)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .user_input (user_input),
    .next_input (next_input),
    .done_input (done_input),
    .q          (q),
    .cur        (cur),
    .sym_count  (sym_count),
    .char_count (char_count),
    .locked     (locked),
    .err        (err)
  );

  always #5 clock = ~clock;

  // Record an expectation at the moment the stimulus implying it is issued
  task automatic expect_val(input string tag, input logic [63:0] val);
    tag_q.push_back(tag);
    val_q.push_back(val);
  endtask

  // Pop the oldest expectation and compare against the observed value
  task automatic check(input logic [63:0] obs);
    string       t;
    logic [63:0] e;
    checks++;
    if (tag_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      t = tag_q.pop_front();
      e = val_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
  endtask

  // Hold the key for n rising edges; returns at the negedge before release is seen
  task automatic press(input int n);
    @(negedge clock);
    user_input = 1'b1;
    repeat (n) @(negedge clock);
    user_input = 1'b0;
  endtask

  task automatic dot();
    press(1);
    repeat (3) @(negedge clock);
  endtask

  task automatic line();
    press(4);
    repeat (3) @(negedge clock);
  endtask

  task automatic nxt();
    @(negedge clock);
    next_input = 1'b1;
    @(negedge clock);
    next_input = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    // Reset values
    do_reset();
    expect_val("rst_q", 64'h0);           check(q);
    expect_val("rst_cur", 64'h0);         check(cur);
    expect_val("rst_sym", 64'h0);         check(sym_count);
    expect_val("rst_char", 64'h0);        check(char_count);
    expect_val("rst_locked", 64'h0);      check(locked);
    expect_val("rst_err", 64'h0);         check(err);

    // dot, line, dot then commit
    dot(); line(); dot();
    expect_val("dld_cur", 64'h01D);       check(cur);
    expect_val("dld_sym", 64'd3);         check(sym_count);
    nxt();
    expect_val("dld_q", 64'h01D);         check(q);
    expect_val("dld_char", 64'd1);        check(char_count);
    expect_val("dld_cur0", 64'h0);        check(cur);
    expect_val("dld_err", 64'h0);         check(err);
    // next with empty character is ignored
    nxt();
    expect_val("empty_next_char", 64'd1); check(char_count);
    expect_val("empty_next_err", 64'h0);  check(err);

    // Six dots overflow the character
    do_reset();
    repeat (5) dot();
    expect_val("five_dot_cur", 64'h155);  check(cur);
    expect_val("five_dot_sym", 64'd5);    check(sym_count);
    expect_val("five_dot_err", 64'h0);    check(err);
    dot();
    expect_val("six_dot_cur", 64'h155);   check(cur);
    expect_val("six_dot_sym", 64'd5);     check(sym_count);
    expect_val("six_dot_err", 64'h1);     check(err);

    // Five single-line characters into four slots
    do_reset();
    for (int i = 0; i < 4; i++) begin
      line(); nxt();
    end
    expect_val("four_chr_err", 64'h0);    check(err);
    expect_val("four_chr_char", 64'd4);   check(char_count);
    line(); nxt();
    expect_val("fifth_q", 64'hC0300C03);  check(q);
    expect_val("fifth_char", 64'd4);      check(char_count);
    expect_val("fifth_err", 64'h1);       check(err);
    expect_val("fifth_cur", 64'h0);       check(cur);
    expect_val("fifth_sym", 64'h0);       check(sym_count);

    // Line then held done: implicit commit and lock
    do_reset();
    line();
    @(negedge clock);
    done_input = 1'b1;
    @(negedge clock);
    expect_val("done_locked", 64'h1);     check(locked);
    expect_val("done_q", 64'h003);        check(q);
    expect_val("done_char", 64'd1);       check(char_count);
    repeat (19) @(negedge clock);
    done_input = 1'b0;
    dot(); nxt();
    @(negedge clock);
    done_input = 1'b1;
    @(negedge clock);
    done_input = 1'b0;
    line();
    expect_val("lock_q", 64'h003);        check(q);
    expect_val("lock_cur", 64'h0);        check(cur);
    expect_val("lock_sym", 64'h0);        check(sym_count);
    expect_val("lock_char", 64'd1);       check(char_count);
    expect_val("lock_locked", 64'h1);     check(locked);
    expect_val("lock_err", 64'h0);        check(err);

    // Asynchronous reset mid-character
    do_reset();
    dot(); dot(); line(); nxt();
    dot(); dot(); dot();
    expect_val("mid_sym", 64'd3);         check(sym_count);
    @(posedge clock);
    #2 resetn = 1'b0;
    #1;
    expect_val("async_q", 64'h0);         check(q);
    expect_val("async_cur", 64'h0);       check(cur);
    expect_val("async_sym", 64'h0);       check(sym_count);
    expect_val("async_char", 64'h0);      check(char_count);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    // Line strobe coincident with next edge after one dot
    do_reset();
    dot();
    press(4);
    @(negedge clock);
    next_input = 1'b1;
    @(negedge clock);
    next_input = 1'b0;
    repeat (2) @(negedge clock);
    expect_val("same_cyc_q", 64'h007);    check(q);
    expect_val("same_cyc_char", 64'd1);   check(char_count);
    expect_val("same_cyc_cur", 64'h0);    check(cur);

    // Button held through reset release does not commit
    @(negedge clock);
    resetn = 1'b0;
    next_input = 1'b1;
    @(negedge clock);
    resetn = 1'b1;
    dot();
    repeat (2) @(negedge clock);
    expect_val("held_char", 64'd0);       check(char_count);
    expect_val("held_sym", 64'd1);        check(sym_count);
    next_input = 1'b0;
    nxt();
    expect_val("held_after_char", 64'd1); check(char_count);
    expect_val("held_after_q", 64'h001);  check(q);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_player_entry
`default_nettype wire

// File: doc/player_entry.md
PLAYER_ENTRY -- requirements
Module: player_entry

Interface
REQ-001 Parameter SYMBOLS, default 5: maximum morse symbols per character.
REQ-002 Parameter CHARS, default 4: maximum committed characters per entry.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 resetn  input  1  reset, asynchronous and active-low.
REQ-005 user_input  input  1  raw key level from the player; feeds the symbol decoder.
REQ-006 next_input  input  1  level from the player's button; its rising edge commits the current character.
REQ-007 done_input  input  1  level from the player's button; its rising edge finishes the entry.
REQ-008 q  output  2*SYMBOLS*CHARS  packed committed characters; slot i occupies bits [2*SYMBOLS*(i+1)-1 : 2*SYMBOLS*i].
REQ-009 cur  output  2*SYMBOLS  character currently being keyed.
REQ-010 sym_count  output  clog2(SYMBOLS+1)  number of symbols in cur.
REQ-011 char_count  output  clog2(CHARS+1)  number of committed slots.
REQ-012 locked  output  1  entry finished; all input ignored.
REQ-013 err  output  1  sticky flag: symbol or character dropped.

Function
REQ-014 Symbol encoding: dot = 01, line = 11, empty = 00; each symbol is 2 bits.
REQ-015 An accepted symbol is appended at the LSBs: cur <= {cur[2*SYMBOLS-3:0], code}, and sym_count increments. Latency is 1 cycle after the decoder strobe.
REQ-016 If the dot and line strobes are both asserted in one cycle, the line is taken.
REQ-017 A symbol arriving when sym_count == SYMBOLS is dropped; cur is unchanged and err is set.
REQ-018 next_input and done_input are edge-detected against a registered copy of each, so a held button acts exactly once.
REQ-019 The next edge with sym_count > 0 and char_count < CHARS does the following in one cycle:
  - writes cur to slot char_count;
  - increments char_count;
  - clears cur and sym_count.
REQ-020 The next edge with sym_count == 0 is ignored and does not set err.
REQ-021 The next edge with sym_count > 0 and char_count == CHARS drops the character:
  - cur and sym_count are cleared;
  - err is set.
REQ-022 A symbol strobe and a next edge in the same cycle: the symbol is appended first, then the result is committed (subject to REQ-017/019/021).
REQ-023 State machine with two states:
  - ENTRY: the normal state;
  - LOCKED: entered on a done edge.
REQ-024 A done edge in ENTRY performs an implicit commit per REQ-019–021 (including any same-cycle symbol), then moves to LOCKED. locked rises 1 cycle after the edge.
REQ-025 A done edge and a next edge in the same cycle cause a single commit only.
REQ-026 In LOCKED:
  - symbols, next and done are ignored;
  - all outputs hold;
  - only resetn leaves the state.
REQ-027 Unused slots (index >= char_count) read as all zeros.

Reset
REQ-028 While resetn is low: q, cur, sym_count, char_count, err, locked and both edge registers are 0, and the state is ENTRY.
REQ-029 Reset takes effect immediately, including mid-character and in LOCKED; the decoder is reset by the same resetn.
REQ-030 After resetn deasserts, a button already held high does not produce an edge.

Structure
REQ-031 Symbol codes (DOT = 2'b01, LINE = 2'b11, EMPTY = 2'b00) and the state encodings live in the shared morse package, used by all player blocks.
REQ-032 One sub-module: morse_decoder (clock, user_input, resetn -> ld_dot, ld_line), instantiated unchanged; edge detect and storage are local.

Verification (SYMBOLS=5, CHARS=4)
REQ-033 Input dot, line, dot, then a next edge gives:
  - slot 0 = 10'b00_0001_1101;
  - char_count = 1;
  - cur = 0;
  - err = 0.
REQ-034 Six dots without next gives:
  - cur = 10'h155;
  - sym_count = 5;
  - err = 1 after the 6th dot.
REQ-035 Five single-line characters, each followed by a next edge, gives:
  - slots 0–3 = 10'h003;
  - char_count = 4;
  - err = 1;
  - cur = 0.
REQ-036 Line, then a done edge held for 20 cycles, then a dot and a next edge, gives:
  - slot 0 = 10'h003;
  - locked = 1;
  - outputs unchanged afterwards.
REQ-037 Reset asserted mid-character (sym_count = 3) clears all outputs asynchronously, before the next clock edge.
REQ-038 A line strobe in the same cycle as a next edge, after one prior dot, gives slot 0 = 10'h007.
